// File: rtl/adc_scan_sequencer.sv
// Round-robin ADC channel scheduler: selects enabled channels in turn, drops settling
// samples, captures one sample per channel and hands it out on a valid/ready stream.
module adc_scan_sequencer #(
    parameter int unsigned DISCARD = 1,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_i,
    input  logic [15:0] ch_enable_i,
    output logic [3:0]  channel_o,
    input  logic        new_sample_i,
    input  logic [9:0]  sample_i,
    input  logic [3:0]  sample_channel_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [9:0]  out_data_o,
    output logic [3:0]  out_channel_o,
    output logic        scan_done_o,
    output logic        timeout_err_o
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_DISCARD,
        S_CAPTURE,
        S_OUTPUT
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      channel_q, channel_d;
    logic [3:0]      ptr_q, ptr_d;
    logic [3:0]      disc_q, disc_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            out_valid_q, out_valid_d;
    logic [9:0]      out_data_q, out_data_d;
    logic [3:0]      out_channel_q, out_channel_d;

    logic            match;
    logic            handshake;
    logic            expired;
    logic            above_set;
    logic [3:0]      next_ch;

    assign match     = new_sample_i && (sample_channel_i == channel_q);
    assign handshake = out_valid_q && out_ready_i;
    assign expired   = !match && (to_q == TO_W'(TIMEOUT - 1));

    // Search starts just above the pointer, so the pointer's own bit is visited last.
    always_comb begin : next_search
        logic [3:0] idx;
        logic       found;
        next_ch = ptr_q;
        found   = 1'b0;
        idx     = '0;
        for (int i = 1; i <= 16; i++) begin
            idx = ptr_q + 4'(i);
            if (!found && ch_enable_i[idx]) begin
                next_ch = idx;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        above_set = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > int'(out_channel_q) && ch_enable_i[i]) begin
                above_set = 1'b1;
            end
        end
    end

    assign scan_done_o   = handshake && (!above_set || $onehot(ch_enable_i));
    assign timeout_err_o = ((state_q == S_DISCARD) || (state_q == S_CAPTURE)) && expired;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        state_d       = state_q;
        channel_d     = channel_q;
        ptr_d         = ptr_q;
        disc_d        = disc_q;
        to_d          = to_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;

        unique case (state_q)
            S_IDLE: begin
                if (run_i && (ch_enable_i != '0)) state_d = S_SELECT;
            end
            S_SELECT: begin
                if (!run_i || (ch_enable_i == '0)) begin
                    state_d = S_IDLE;
                end else begin
                    channel_d = next_ch;
                    ptr_d     = next_ch;
                    disc_d    = '0;
                    to_d      = '0;
                    state_d   = (DISCARD > 0) ? S_DISCARD : S_CAPTURE;
                end
            end
            S_DISCARD: begin
                if (match) begin
                    to_d   = '0;
                    disc_d = disc_q + 4'd1;
                    if (32'(disc_q) + 32'd1 >= DISCARD) state_d = S_CAPTURE;
                end else if (expired) begin
                    state_d = S_SELECT;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_CAPTURE: begin
                if (match) begin
                    out_data_d    = sample_i;
                    out_channel_d = channel_q;
                    out_valid_d   = 1'b1;
                    state_d       = S_OUTPUT;
                end else if (expired) begin
                    state_d = S_SELECT;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_OUTPUT: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    state_d     = S_SELECT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            channel_q     <= '0;
            ptr_q         <= 4'hF;
            disc_q        <= '0;
            to_q          <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_channel_q <= '0;
        end else begin
            state_q       <= state_d;
            channel_q     <= channel_d;
            ptr_q         <= ptr_d;
            disc_q        <= disc_d;
            to_q          <= to_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
        end
    end

    assign channel_o     = channel_q;
    assign out_valid_o   = out_valid_q;
    assign out_data_o    = out_data_q;
    assign out_channel_o = out_channel_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: two instances (DISCARD=1 and DISCARD=0, TIMEOUT=20)
// checked every cycle against a transaction-level model plus literal expectations.
`timescale 1ns/1ps
module tb_adc_scan_sequencer;

    localparam int TO = 20;
    localparam int P_IDLE = 0, P_PICK = 1, P_GATHER = 2, P_HOLD = 3;

    typedef struct {
        int ph;
        int ch;
        int ptr;
        int hits;
        int quiet;
        int ov;
        int od;
        int oc;
    } mdl_t;

    typedef struct {
        int ch;
        int d;
        int sd;
    } hs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s  [2];
    logic        run_s  [2];
    logic [15:0] en_s   [2];
    logic        ns_s   [2];
    logic [9:0]  smp_s  [2];
    logic [3:0]  sch_s  [2];
    logic        rdy_s  [2];
    logic [3:0]  chan_o [2];
    logic        ov_o   [2];
    logic [9:0]  od_o   [2];
    logic [3:0]  oc_o   [2];
    logic        sd_o   [2];
    logic        te_o   [2];

    int   n_total = 0;
    int   n_pass  = 0;
    bit   chk_en  = 1'b0;
    mdl_t m0, m1;
    hs_t  log0 [$];
    hs_t  log1 [$];

    int e0_ch [4] = '{0, 2, 0, 2};
    int e0_d  [4] = '{'h022, 'h044, 'h1FF, 'h2A5};
    int e0_sd [4] = '{0, 1, 0, 1};
    int e1_ch [5] = '{0, 15, 0, 15, 0};
    int e1_d  [5] = '{'h101, 'h1F0, 'h102, 'h1F1, 'h103};
    int e1_sd [5] = '{0, 1, 0, 1, 1};

    adc_scan_sequencer #(.DISCARD(1), .TIMEOUT(TO)) u_dut0 (
        .clk(clk), .rst(rst_s[0]), .run_i(run_s[0]), .ch_enable_i(en_s[0]),
        .channel_o(chan_o[0]), .new_sample_i(ns_s[0]), .sample_i(smp_s[0]),
        .sample_channel_i(sch_s[0]), .out_valid_o(ov_o[0]), .out_ready_i(rdy_s[0]),
        .out_data_o(od_o[0]), .out_channel_o(oc_o[0]), .scan_done_o(sd_o[0]),
        .timeout_err_o(te_o[0])
    );

    adc_scan_sequencer #(.DISCARD(0), .TIMEOUT(TO)) u_dut1 (
        .clk(clk), .rst(rst_s[1]), .run_i(run_s[1]), .ch_enable_i(en_s[1]),
        .channel_o(chan_o[1]), .new_sample_i(ns_s[1]), .sample_i(smp_s[1]),
        .sample_channel_i(sch_s[1]), .out_valid_o(ov_o[1]), .out_ready_i(rdy_s[1]),
        .out_data_o(od_o[1]), .out_channel_o(oc_o[1]), .scan_done_o(sd_o[1]),
        .timeout_err_o(te_o[1])
    );

    // ---------------- reference model ----------------
    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.ph = P_IDLE; r.ch = 0; r.ptr = 15; r.hits = 0; r.quiet = 0;
        r.ov = 0; r.od = 0; r.oc = 0;
        return r;
    endfunction

    function automatic int next_enabled(int after, logic [15:0] en);
        for (int k = 1; k <= 16; k++) begin
            if (en[(after + k) % 16]) return (after + k) % 16;
        end
        return after;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int disc, logic run, logic [15:0] en,
                                      logic ns, int smp, int sch, logic rdy);
        mdl_t n;
        bit   hit;
        n   = m;
        hit = ns && (sch == m.ch);
        case (m.ph)
            P_IDLE:   if (run && en != 16'd0) n.ph = P_PICK;
            P_PICK: begin
                if (!run || en == 16'd0) begin
                    n.ph = P_IDLE;
                end else begin
                    n.ch = next_enabled(m.ptr, en);
                    n.ptr = n.ch; n.hits = 0; n.quiet = 0; n.ph = P_GATHER;
                end
            end
            P_GATHER: begin
                if (hit) begin
                    n.quiet = 0;
                    n.hits  = m.hits + 1;
                    if (n.hits == disc + 1) begin
                        n.ov = 1; n.od = smp; n.oc = m.ch; n.ph = P_HOLD;
                    end
                end else if (m.quiet + 1 == TO) begin
                    n.ph = P_PICK;
                end else begin
                    n.quiet = m.quiet + 1;
                end
            end
            P_HOLD: if (rdy) begin n.ov = 0; n.ph = P_PICK; end
            default: n.ph = P_IDLE;
        endcase
        return n;
    endfunction

    function automatic int exp_sd(mdl_t m, logic [15:0] en, logic rdy);
        if (!(m.ov != 0 && rdy)) return 0;
        if ($countones(en) == 1) return 1;
        return ((en >> (m.oc + 1)) == 16'd0) ? 1 : 0;
    endfunction

    function automatic int exp_te(mdl_t m, logic ns, int sch);
        return (m.ph == P_GATHER && !(ns && sch == m.ch) && m.quiet == TO - 1) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        m0 <= rst_s[0] ? mdl_reset() : mdl_step(m0, 1, run_s[0], en_s[0], ns_s[0],
                                                int'(smp_s[0]), int'(sch_s[0]), rdy_s[0]);
        m1 <= rst_s[1] ? mdl_reset() : mdl_step(m1, 0, run_s[1], en_s[1], ns_s[1],
                                                int'(smp_s[1]), int'(sch_s[1]), rdy_s[1]);
    end

    // ---------------- checking ----------------
    task automatic check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cmp_unit(int u, mdl_t m);
        hs_t h;
        check($sformatf("u%0d channel", u),     int'(chan_o[u]), m.ch);
        check($sformatf("u%0d out_valid", u),   int'(ov_o[u]),   m.ov);
        check($sformatf("u%0d out_data", u),    int'(od_o[u]),   m.od);
        check($sformatf("u%0d out_channel", u), int'(oc_o[u]),   m.oc);
        check($sformatf("u%0d scan_done", u),   int'(sd_o[u]),   exp_sd(m, en_s[u], rdy_s[u]));
        check($sformatf("u%0d timeout_err", u), int'(te_o[u]),   exp_te(m, ns_s[u], int'(sch_s[u])));
        if (ov_o[u] && rdy_s[u]) begin
            h.ch = int'(oc_o[u]); h.d = int'(od_o[u]); h.sd = int'(sd_o[u]);
            if (u == 0) log0.push_back(h);
            else        log1.push_back(h);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_unit(0, m0);
            cmp_unit(1, m1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int u, int ch, int val);
        ns_s[u]  = 1'b1;
        sch_s[u] = 4'(ch);
        smp_s[u] = 10'(val);
        tick();
        ns_s[u]  = 1'b0;
    endtask

    task automatic wait_collect(int u, int ch);
        mdl_t mm;
        bit   ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (u == 0) mm = m0;
            else        mm = m1;
            if (mm.ph == P_GATHER && mm.ch == ch) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check($sformatf("u%0d reach ch%0d", u, ch), int'(ok), 1);
    endtask

    initial begin
        int k_hit;
        for (int u = 0; u < 2; u++) begin
            rst_s[u] = 1'b1; run_s[u] = 1'b0; en_s[u] = '0; ns_s[u] = 1'b0;
            smp_s[u] = '0;   sch_s[u] = '0;   rdy_s[u] = 1'b0;
        end
        repeat (2) tick();
        for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d reset channel", u),   int'(chan_o[u]), 0);
            check($sformatf("u%0d reset out_valid", u), int'(ov_o[u]),   0);
            check($sformatf("u%0d reset out_data", u),  int'(od_o[u]),   0);
            check($sformatf("u%0d reset out_chan", u),  int'(oc_o[u]),   0);
            check($sformatf("u%0d reset scan_done", u), int'(sd_o[u]),   0);
            check($sformatf("u%0d reset timeout", u),   int'(te_o[u]),   0);
        end
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;
        chk_en   = 1'b1;

        // Two-channel scan with one discarded sample per channel.
        en_s[0] = 16'h0005; run_s[0] = 1'b1; rdy_s[0] = 1'b1;
        wait_collect(0, 0); send(0, 0, 'h011); send(0, 0, 'h022);
        wait_collect(0, 2); send(0, 2, 'h033); send(0, 2, 'h044);
        wait_collect(0, 0);
        check("u0 back to ch0", int'(chan_o[0]), 0);

        // Foreign-channel samples ignored, then backpressure on a captured 0x1FF.
        rdy_s[0] = 1'b0;
        send(0, 3, 'h0AA); send(0, 3, 'h0BB);
        send(0, 0, 'h155); send(0, 0, 'h1FF);
        for (int i = 0; i < 10; i++) begin
            check("bp out_valid",   int'(ov_o[0]),   1);
            check("bp out_data",    int'(od_o[0]),   'h1FF);
            check("bp out_channel", int'(oc_o[0]),   0);
            check("bp channel",     int'(chan_o[0]), 0);
            tick();
        end
        rdy_s[0] = 1'b1;
        tick();

        // run drops during capture: sample still delivered, then idle on ch2.
        wait_collect(0, 2); send(0, 2, 'h010);
        run_s[0] = 1'b0;
        tick(); tick();
        send(0, 2, 'h2A5);
        repeat (5) tick();
        check("idle channel held", int'(chan_o[0]), 2);
        check("idle out_valid",    int'(ov_o[0]),   0);

        // Timeout on ch1 with mask 0x0006.
        en_s[0] = 16'h0006; run_s[0] = 1'b1;
        tick(); tick();
        check("timeout sel ch1", int'(chan_o[0]), 1);
        k_hit = -1;
        for (int k = 0; k < 40; k++) begin
            if (te_o[0]) begin
                k_hit = k;
                break;
            end
            tick();
        end
        check("timeout cycle after SELECT+1", k_hit, 19);
        tick(); tick();
        check("after timeout ch2", int'(chan_o[0]), 2);
        check("no output on timeout", log0.size(), 4);

        // Reset while out_valid is high; pointer must restart from the bottom.
        rdy_s[0] = 1'b0;
        send(0, 2, 'h077); send(0, 2, 'h3C3);
        check("pre-reset out_valid", int'(ov_o[0]), 1);
        check("pre-reset out_data",  int'(od_o[0]), 'h3C3);
        rst_s[0] = 1'b1;
        en_s[0]  = 16'h000C;
        tick();
        check("reset out_valid", int'(ov_o[0]),   0);
        check("reset channel",   int'(chan_o[0]), 0);
        rst_s[0] = 1'b0;
        rdy_s[0] = 1'b1;
        tick(); tick();
        check("post-reset lowest ch", int'(chan_o[0]), 2);
        run_s[0] = 1'b0;
        repeat (25) tick();

        // Wrap 15->0 with no discard, then one-hot mask swapped mid-channel.
        en_s[1] = 16'h8001; run_s[1] = 1'b1; rdy_s[1] = 1'b1;
        wait_collect(1, 0);  send(1, 0, 'h101);
        wait_collect(1, 15); send(1, 15, 'h1F0);
        wait_collect(1, 0);  send(1, 0, 'h102);
        wait_collect(1, 15); send(1, 15, 'h1F1);
        wait_collect(1, 0);
        en_s[1] = 16'h0100;
        send(1, 0, 'h103);
        wait_collect(1, 8);
        check("u1 selects ch8", int'(chan_o[1]), 8);
        run_s[1] = 1'b0;
        repeat (25) tick();

        chk_en = 1'b0;
        check("u0 handshake count", log0.size(), 4);
        for (int i = 0; i < 4 && i < log0.size(); i++) begin
            check($sformatf("u0 hs%0d ch", i), log0[i].ch, e0_ch[i]);
            check($sformatf("u0 hs%0d data", i), log0[i].d, e0_d[i]);
            check($sformatf("u0 hs%0d scan_done", i), log0[i].sd, e0_sd[i]);
        end
        check("u1 handshake count", log1.size(), 5);
        for (int i = 0; i < 5 && i < log1.size(); i++) begin
            check($sformatf("u1 hs%0d ch", i), log1[i].ch, e1_ch[i]);
            check($sformatf("u1 hs%0d data", i), log1[i].d, e1_d[i]);
            check($sformatf("u1 hs%0d scan_done", i), log1[i].sd, e1_sd[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
